// File: rtl/unum_add_arbiter.sv
// Two-requester round-robin front end for one shared pipelined unum adder, with per-requester result FIFOs.
// Latency: result is visible on respN_sum LAT+1 cycles after the accept cycle when the FIFO is empty.
// Backpressure: credit-based, so a requester is refused while its FIFO entries plus in-flight ops reach DEPTH. Optional stats: UNUM_ADD_ARBITER_STATS_EN.
module unum_add_arbiter #(
    parameter int LAT   = 8,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic [31:0] resp0_sum,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp1_sum,
    output logic [31:0] add_unum1,
    output logic [31:0] add_unum2,
    input  logic [31:0] add_result,
    output logic        busy
`ifdef UNUM_ADD_ARBITER_STATS_EN
    ,
    output logic [15:0] stat0_issue,
    output logic [15:0] stat1_issue,
    output logic [15:0] stat_stall
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    vld;
    logic [1:0]    elig;
    logic [1:0]    cand;
    logic [1:0]    grant;
    logic          accept;
    logic          rr;          // 0: favour req0 on contention, 1: favour req1
    logic [CW-1:0] fcnt [2];
    logic [CW-1:0] infl [2];
    logic [CW:0]   used [2];
    logic [AW-1:0] wp   [2];
    logic [AW-1:0] rp   [2];
    logic [31:0]   mem  [2][DEPTH];
    logic [LAT:1]  tv;          // tag valid per pipeline stage
    logic [LAT:1]  tt;          // tag requester id per pipeline stage
    logic          retire;
    logic [1:0]    wr;
    logic [1:0]    rd;
    logic [1:0]    rvld;
    logic [1:0]    rrdy;

    assign vld  = {req1_valid, req0_valid};
    assign rrdy = {resp1_ready, resp0_ready};

    // Credit check and round-robin grant; reset forces no grant.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            used[i] = {1'b0, fcnt[i]} + {1'b0, infl[i]};
            elig[i] = used[i] < (CW + 1)'(DEPTH);
        end
        cand  = vld & elig & {2{~rst}};
        grant = cand;
        if (cand == 2'b11) begin
            grant = rr ? 2'b10 : 2'b01;
        end
    end

    assign accept     = |grant;
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Steer the granted operands to the shared adder, zero when idle.
    always_comb begin
        add_unum1 = 32'd0;
        add_unum2 = 32'd0;
        if (grant[0]) begin
            add_unum1 = req0_a;
            add_unum2 = req0_b;
        end else if (grant[1]) begin
            add_unum1 = req1_a;
            add_unum2 = req1_b;
        end
    end

    // Tag pipeline mirrors the adder: stage LAT lines up with add_result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tv <= '0;
            tt <= '0;
        end else begin
            tv[1] <= accept;
            tt[1] <= grant[1];
            for (int k = 2; k <= LAT; k++) begin
                tv[k] <= tv[k-1];
                tt[k] <= tt[k-1];
            end
        end
    end

    assign retire = tv[LAT];
    assign wr[0]  = retire & ~tt[LAT];
    assign wr[1]  = retire &  tt[LAT];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            rvld[i] = fcnt[i] != '0;
            rd[i]   = rvld[i] & rrdy[i];
        end
    end

    // Round-robin pointer: after any grant, favour the other requester.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (accept) begin
            rr <= ~grant[1];
        end
    end

    // FIFO pointers, occupancy and in-flight credits; the credit rule means a write never meets a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wp[i]   <= '0;
                rp[i]   <= '0;
                fcnt[i] <= '0;
                infl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr[i]) wp[i] <= wp[i] + 1'b1;
                if (rd[i]) rp[i] <= rp[i] + 1'b1;
                fcnt[i] <= fcnt[i] + CW'(wr[i]) - CW'(rd[i]);
                infl[i] <= infl[i] + CW'(grant[i]) - CW'(wr[i]);
            end
        end
    end

    // Result storage; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr[i]) mem[i][wp[i]] <= add_result;
        end
    end

    assign resp0_valid = rvld[0];
    assign resp1_valid = rvld[1];
    assign resp0_sum   = rvld[0] ? mem[0][rp[0]] : 32'd0;
    assign resp1_sum   = rvld[1] ? mem[1][rp[1]] : 32'd0;
    assign busy        = (infl[0] != '0) | (infl[1] != '0) | rvld[0] | rvld[1];

`ifdef UNUM_ADD_ARBITER_STATS_EN
    // Issue counters per requester and a cycle count of valid requests left unaccepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0_issue <= 16'd0;
            stat1_issue <= 16'd0;
            stat_stall  <= 16'd0;
        end else begin
            if (grant[0]) stat0_issue <= stat0_issue + 16'd1;
            if (grant[1]) stat1_issue <= stat1_issue + 16'd1;
            if (|(vld & ~grant)) stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unum_add_arbiter.sv
// Directed bench for unum_add_arbiter with a behavioural pipelined adder.
// Adder model: LAT stages counting the sampling edge.
// Sums are a true unum add for the 1.0+1.0 vector and an integer sum otherwise; the arbiter never looks at data.
module tb_unum_add_arbiter;
    localparam int LAT   = 8;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp0_sum, resp1_sum;
    logic [31:0] add_unum1, add_unum2, add_result;
    logic        busy;
`ifdef UNUM_ADD_ARBITER_STATS_EN
    logic [15:0] stat0_issue, stat1_issue, stat_stall;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] pipe [1:LAT];

    always #5 clk = ~clk;

    unum_add_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_sum(resp0_sum),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_sum(resp1_sum),
        .add_unum1(add_unum1), .add_unum2(add_unum2), .add_result(add_result),
        .busy(busy)
`ifdef UNUM_ADD_ARBITER_STATS_EN
        , .stat0_issue(stat0_issue), .stat1_issue(stat1_issue), .stat_stall(stat_stall)
`endif
    );

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4000_0000) return 32'h4400_0000;
        return a + b;
    endfunction

    // Behavioural shared adder.
    always @(posedge clk) begin
        pipe[1] <= model_add(add_unum1, add_unum2);
        for (int k = 2; k <= LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign add_result = pipe[LAT];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    // Record every response popped, sampling first at the current negedge.
    task automatic collect(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (resp0_valid && resp0_ready) q0.push_back(resp0_sum);
            if (resp1_valid && resp1_ready) q1.push_back(resp1_sum);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, i0, i1, nacc, seen;
        logic g0, g1;

        // Reset state, with both requests valid to show reset masks ready.
        rst = 1'b1;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 32'h1; req0_b = 32'h2; req1_a = 32'h3; req1_b = 32'h4;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_resp0_valid", resp0_valid, 0);
        chk("rst_resp0_sum", resp0_sum, 0);
        chk("rst_add_unum1", add_unum1, 0);
        chk("rst_busy", busy, 0);
        do_reset();

        // Single request: 1.0 + 1.0 on req0.
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h4000_0000; req0_b = 32'h4000_0000;
        #1;
        chk("single_ready", req0_ready, 1);
        chk("single_opnd1", add_unum1, 32'h4000_0000);
        chk("single_opnd2", add_unum2, 32'h4000_0000);
        @(posedge clk); lat = 1;
        @(negedge clk);
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        #1;
        chk("idle_opnd1", add_unum1, 0);
        while (!resp0_valid && lat < 20) begin
            @(posedge clk); lat++;
            @(negedge clk);
        end
        chk("single_latency", lat, 9);
        chk("single_sum", resp0_sum, 32'h4400_0000);
        @(negedge clk); #1;
        chk("single_drained_valid", resp0_valid, 0);
        chk("single_busy_low", busy, 0);

        // Contention: both valid for 6 cycles, operands held until accepted.
        do_reset();
        i0 = 0; i1 = 0;
        for (int k = 0; k < 6; k++) begin
            req0_valid = 1'b1; req0_a = 32'h10 + i0; req0_b = 32'h100;
            req1_valid = 1'b1; req1_a = 32'h20 + i1; req1_b = 32'h200;
            #1;
            chk("rr_grant", {req1_ready, req0_ready}, (k % 2 == 0) ? 2'b01 : 2'b10);
            g0 = req0_ready; g1 = req1_ready;
            @(negedge clk);
            if (g0) i0++;
            if (g1) i1++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        q0.delete(); q1.delete();
        collect(30);
        chk("rr_count0", q0.size(), 3);
        chk("rr_count1", q1.size(), 3);
        for (int j = 0; j < 3; j++) begin
            chk("rr_order0", (j < q0.size()) ? q0[j] : 32'hDEAD_BEEF, 32'h110 + j);
            chk("rr_order1", (j < q1.size()) ? q1[j] : 32'hDEAD_BEEF, 32'h220 + j);
        end

        // Backpressure on requester 1.
        resp1_ready = 1'b0; resp0_ready = 1'b1;
        i1 = 0; nacc = 0;
        for (int c = 0; c < 30; c++) begin
            req1_valid = 1'b1; req1_a = 32'h300 + i1; req1_b = 32'h0;
            #1;
            g1 = req1_ready;
            @(negedge clk);
            if (g1) begin nacc++; i1++; end
        end
        chk("bp_accepts", nacc, DEPTH);
        #1;
        chk("bp_ready_low", req1_ready, 0);
        chk("bp_resp_valid", resp1_valid, 1);
        chk("bp_busy", busy, 1);
        req1_valid = 1'b0;
        resp1_ready = 1'b1;
        q1.delete();
        collect(12);
        chk("bp_drain_count", q1.size(), DEPTH);
        for (int j = 0; j < DEPTH; j++)
            chk("bp_drain_order", (j < q1.size()) ? q1[j] : 32'hDEAD_BEEF, 32'h300 + j);

        // Full FIFO0, then a read and a retire on the same edge.
        resp0_ready = 1'b0;
        i0 = 0;
        for (int c = 0; c < 20; c++) begin
            req0_valid = 1'b1; req0_a = 32'h400 + i0; req0_b = 32'h0;
            #1;
            g0 = req0_ready;
            @(negedge clk);
            if (g0) i0++;
        end
        chk("full_accepts", i0, DEPTH);
        req0_a = 32'h408;
        q0.delete();
        resp0_ready = 1'b1;
        #1;
        if (resp0_valid) q0.push_back(resp0_sum);
        @(negedge clk);
        resp0_ready = 1'b0;
        #1;
        chk("full_credit_back", req0_ready, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) req0_valid = 1'b0;
            if (k == 8) resp0_ready = 1'b1;
        end
        collect(15);
        chk("simul_count", q0.size(), DEPTH + 1);
        for (int j = 0; j <= DEPTH; j++)
            chk("simul_order", (j < q0.size()) ? q0[j] : 32'hDEAD_BEEF, 32'h400 + j);

        // Reset asserted while three operations are in flight.
        resp0_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req0_valid = 1'b1; req0_a = 32'h500 + c; req0_b = 32'h0;
            #1;
            chk("mid_accept", req0_ready, 1);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("mid_rst_ready0", req0_ready, 0);
        chk("mid_rst_ready1", req1_ready, 0);
        chk("mid_rst_resp0_valid", resp0_valid, 0);
        chk("mid_rst_resp0_sum", resp0_sum, 0);
        chk("mid_rst_opnd1", add_unum1, 0);
        chk("mid_rst_opnd2", add_unum2, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (resp0_valid || resp1_valid) seen++;
        end
        chk("mid_no_stale_resp", seen, 0);

`ifdef UNUM_ADD_ARBITER_STATS_EN
        // Statistics: 5 req0 accepts, req1 wins twice, req0 loses twice.
        do_reset();
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req0_valid = 1'b1; req0_a = 32'h600 + c; req0_b = 32'h0;
            req1_valid = (c == 1 || c == 3); req1_a = 32'h700 + c; req1_b = 32'h0;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk("stat0_issue", stat0_issue, 5);
        chk("stat1_issue", stat1_issue, 2);
        chk("stat_stall", stat_stall, 2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
